dram_arbiter: RTL and testbench
===============================

// Module: dram_arbiter
// PURPOSE
//  Shares the single data-RAM port between the stack CPU (sm_logics) and the UART debug logic (uart_logics).
//  Two-phase FSM: sample requests, then issue one RAM access. Read data is returned to the granted requester.
//  CPU has fixed priority with a starvation guard. uart_lock (dump in progress) gives the UART exclusive ownership.
//  Sits between both requesters and the data-RAM port of ramblk.
// PARAMETERS
//  AW          5  RAM address width
//  DW          8  RAM data width
//  STARVE_MAX  4  consecutive CPU grants while UART waits before the UART is forced a grant (1..2^CW-1)
//  CW          3  starvation counter width
// PORTS
//  clk        in   1   system clock, single clock domain
//  rst        in   1   synchronous reset, active-high
//  cpu_req    in   1   CPU access request; held until cpu_gnt
//  cpu_we     in   1   1=write, 0=read
//  cpu_adr    in   AW  CPU address
//  cpu_wdata  in   DW  CPU write data
//  cpu_gnt    out  1   one-cycle pulse: CPU command issued to RAM this cycle
//  cpu_rvalid out  1   one-cycle pulse: cpu_rdata valid
//  cpu_rdata  out  DW  CPU read data
//  uart_req   in   1   UART access request; held until uart_gnt
//  uart_we    in   1   1=write, 0=read
//  uart_adr   in   AW  UART address
//  uart_wdata in   DW  UART write data
//  uart_lock  in   1   UART exclusive ownership (tie to dump_running)
//  uart_gnt   out  1   one-cycle pulse: UART command issued to RAM this cycle
//  uart_rvalid out 1   one-cycle pulse: uart_rdata valid
//  uart_rdata out  DW  UART read data
//  ram_adr    out  AW  RAM address (registered)
//  ram_wdata  out  DW  RAM write data (registered)
//  ram_wen    out  1   RAM write strobe (registered, high only in ISSUE cycle of a write)
//  ram_rdata  in   DW  RAM read data, valid one cycle after address
// BEHAVIOUR
//  Reset: state=ARB, gnts/rvalids/ram_wen=0, ram_adr=0, ram_wdata=0, starve_cnt=0, owner=CPU; rdata outputs=0.
//  FSM ARB: sample reqs at clock edge. If a winner exists, go to ISSUE, load ram_adr/ram_wdata/ram_wen from the winner, and record the owner.
//   If there is no request, stay in ARB.
//  FSM ISSUE: exactly one cycle. Assert the owner's gnt and drive ram_* from registers. Always return to ARB.
//   Peak throughput is therefore 1 access per 2 cycles.
//  Winner selection, in order of precedence:
//   1. uart_lock=1: only UART may win. cpu_req waits with no grant.
//   2. uart_req && starve_cnt==STARVE_MAX: UART wins.
//   3. cpu_req: CPU wins.
//   4. uart_req: UART wins.
//  starve_cnt:
//   - +1 on each CPU win while uart_req=1, saturating at STARVE_MAX.
//   - Cleared on any UART win, or when uart_req=0 in ARB.
//  Requesters hold req/we/adr/wdata stable until gnt. Commands are captured at the ARB edge, so changes during ISSUE are harmless.
//   In the gnt cycle a requester may present its next command. It is sampled in the following ARB cycle.
//  Read return: a read issued in ISSUE cycle T produces owner rvalid=1 in T+1, with rdata=ram_rdata (registered copy held until the next read).
//   Writes produce no rvalid. The rvalid of ISSUE(T) coincides with the next ARB cycle.
//  uart_lock rising while a CPU access is in ISSUE: that access completes normally. Lock applies from the next ARB.
//  Simultaneous cpu_req & uart_req with cnt<STARVE_MAX and no lock: CPU wins and the UART waits.
//  Reset mid-operation: aborts ISSUE and suppresses any pending rvalid. ram_wen=0 in the cycle after rst.
//  Address/data widths pass through unchanged. No wrap arithmetic is applied to addresses.
// TESTING
//  1. CPU write adr=5 data=0xA3, then CPU read adr=5 -> ram_wen pulse with adr=5, then cpu_rvalid with cpu_rdata=0xA3. uart_gnt never asserts.
//  2. cpu_req and uart_req both held continuously, STARVE_MAX=4 -> grant order C,C,C,C,U repeating. No request waits more than 5 grants.
//  3. uart_lock=1 with both reqs held -> only uart_gnt pulses, every 2nd cycle. After lock drops, the first grant goes to CPU.
//  4. UART read adr=31 followed immediately by CPU read adr=0 -> uart_rvalid with RAM[31], then cpu_rvalid with RAM[0]. The rvalids never overlap and never cross owners.
//  5. rst=1 in the ISSUE cycle of a read -> no rvalid is produced. All outputs read the reset values on the next cycle.
//  6. A single requester holds req for 10 cycles -> 5 gnt pulses, each separated by one ARB cycle.

Source files
------------

// File: rtl/dram_arbiter.sv
// dram_arbiter
//   Shares the single data-RAM port between the stack CPU and the UART
//   debug logic. A two-phase FSM alternates between ARB and ISSUE:
//   - ARB samples both requests, picks a winner, and loads the RAM
//     command registers.
//   - ISSUE presents that command to the RAM for exactly one cycle.
//   Read data comes back to whichever requester issued the read.
//   The CPU has fixed priority, with a starvation guard for the UART.
//   uart_lock gives the UART exclusive ownership of the port.
//
// Ports
//   clk, rst            system clock, synchronous active-high reset
//   cpu_req/we/adr/wdata  CPU command, held until cpu_gnt
//   cpu_gnt             pulse: CPU command is on the RAM port this cycle
//   cpu_rvalid/rdata    CPU read return, one cycle after its ISSUE
//   uart_req/we/adr/wdata UART command, held until uart_gnt
//   uart_lock           UART exclusive ownership (dump in progress)
//   uart_gnt            pulse: UART command is on the RAM port this cycle
//   uart_rvalid/rdata   UART read return, one cycle after its ISSUE
//   ram_adr/wdata/wen   registered RAM command
//   ram_rdata           RAM read data, valid one cycle after the address
module dram_arbiter #(
  parameter int AW         = 5,
  parameter int DW         = 8,
  parameter int STARVE_MAX = 4,
  parameter int CW         = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_adr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          uart_req,
  input  logic          uart_we,
  input  logic [AW-1:0] uart_adr,
  input  logic [DW-1:0] uart_wdata,
  input  logic          uart_lock,
  output logic          uart_gnt,
  output logic          uart_rvalid,
  output logic [DW-1:0] uart_rdata,
  output logic [AW-1:0] ram_adr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_wen,
  input  logic [DW-1:0] ram_rdata
);

  localparam logic [0:0] ST_ARB   = 1'b0;
  localparam logic [0:0] ST_ISSUE = 1'b1;

  localparam logic OWN_CPU  = 1'b0;
  localparam logic OWN_UART = 1'b1;

  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  logic [0:0]    state;
  logic          owner;
  logic [CW-1:0] starve_cnt;
  logic [AW-1:0] adr_q;
  logic [DW-1:0] wdata_q;
  logic          wen_q;
  logic          cpu_rvalid_q;
  logic          uart_rvalid_q;
  logic [DW-1:0] cpu_rdata_q;
  logic [DW-1:0] uart_rdata_q;

  logic win_valid;
  logic win_uart;

  // Winner selection. Precedence: lock, then the starvation guard,
  // then CPU priority, then the UART as the only remaining requester.
  always_comb begin
    win_valid = 1'b0;
    win_uart  = 1'b0;
    if (uart_lock) begin
      win_valid = uart_req;
      win_uart  = 1'b1;
    end else if (uart_req && (starve_cnt == STARVE_LIM)) begin
      win_valid = 1'b1;
      win_uart  = 1'b1;
    end else if (cpu_req) begin
      win_valid = 1'b1;
      win_uart  = 1'b0;
    end else if (uart_req) begin
      win_valid = 1'b1;
      win_uart  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_ARB;
      owner         <= OWN_CPU;
      starve_cnt    <= '0;
      adr_q         <= '0;
      wdata_q       <= '0;
      wen_q         <= 1'b0;
      cpu_rvalid_q  <= 1'b0;
      uart_rvalid_q <= 1'b0;
      cpu_rdata_q   <= '0;
      uart_rdata_q  <= '0;
    end else begin
      cpu_rvalid_q  <= 1'b0;
      uart_rvalid_q <= 1'b0;

      // The RAM output is only valid in the rvalid cycle, so keep a copy
      // that the rdata outputs can present until the next read returns.
      if (cpu_rvalid_q) begin
        cpu_rdata_q <= ram_rdata;
      end
      if (uart_rvalid_q) begin
        uart_rdata_q <= ram_rdata;
      end

      case (state)
        ST_ARB: begin
          if (win_valid) begin
            state   <= ST_ISSUE;
            owner   <= win_uart;
            adr_q   <= win_uart ? uart_adr   : cpu_adr;
            wdata_q <= win_uart ? uart_wdata : cpu_wdata;
            wen_q   <= win_uart ? uart_we    : cpu_we;
          end
          // Counts CPU wins while the UART is kept waiting.
          if (!uart_req) begin
            starve_cnt <= '0;
          end else if (win_valid && win_uart) begin
            starve_cnt <= '0;
          end else if (win_valid && (starve_cnt != STARVE_LIM)) begin
            starve_cnt <= starve_cnt + CW'(1);
          end
        end
        ST_ISSUE: begin
          state <= ST_ARB;
          wen_q <= 1'b0;
          // The RAM sees the read address this cycle, so the data arrives
          // in the following ARB cycle.
          if (!wen_q) begin
            if (owner == OWN_UART) begin
              uart_rvalid_q <= 1'b1;
            end else begin
              cpu_rvalid_q <= 1'b1;
            end
          end
        end
        default: begin
          state <= ST_ARB;
        end
      endcase
    end
  end

  assign cpu_gnt     = (state == ST_ISSUE) && (owner == OWN_CPU);
  assign uart_gnt    = (state == ST_ISSUE) && (owner == OWN_UART);
  assign cpu_rvalid  = cpu_rvalid_q;
  assign uart_rvalid = uart_rvalid_q;
  assign cpu_rdata   = cpu_rvalid_q  ? ram_rdata : cpu_rdata_q;
  assign uart_rdata  = uart_rvalid_q ? ram_rdata : uart_rdata_q;
  assign ram_adr     = adr_q;
  assign ram_wdata   = wdata_q;
  assign ram_wen     = wen_q;

endmodule

// File: tb/tb_dram_arbiter.sv
// tb_dram_arbiter
//   Directed bench for dram_arbiter with a small behavioural RAM.
//   Inputs change and outputs are sampled on the falling clock edge.
module tb_dram_arbiter;

  logic       clk;
  logic       rst;
  logic       cpuReq, cpuWe, cpuGnt, cpuRvalid;
  logic [4:0] cpuAdr;
  logic [7:0] cpuWdata, cpuRdata;
  logic       uartReq, uartWe, uartLock, uartGnt, uartRvalid;
  logic [4:0] uartAdr;
  logic [7:0] uartWdata, uartRdata;
  logic [4:0] ramAdr;
  logic [7:0] ramWdata, ramRdata;
  logic       ramWen;

  logic [7:0] mem [32];

  int checks = 0;
  int errors = 0;
  int overlapCount = 0;
  int uartGntCount = 0;

  dram_arbiter #(.AW(5), .DW(8), .STARVE_MAX(4), .CW(3)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpuReq), .cpu_we(cpuWe), .cpu_adr(cpuAdr), .cpu_wdata(cpuWdata),
    .cpu_gnt(cpuGnt), .cpu_rvalid(cpuRvalid), .cpu_rdata(cpuRdata),
    .uart_req(uartReq), .uart_we(uartWe), .uart_adr(uartAdr), .uart_wdata(uartWdata),
    .uart_lock(uartLock), .uart_gnt(uartGnt), .uart_rvalid(uartRvalid), .uart_rdata(uartRdata),
    .ram_adr(ramAdr), .ram_wdata(ramWdata), .ram_wen(ramWen), .ram_rdata(ramRdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM: write on wen, read data one cycle after the address.
  always @(posedge clk) begin
    if (ramWen) mem[ramAdr] <= ramWdata;
    ramRdata <= mem[ramAdr];
  end

  // Tracks properties that must hold on every cycle of the run.
  always @(negedge clk) begin
    if (cpuGnt && uartGnt) overlapCount++;
    if (cpuRvalid && uartRvalid) overlapCount++;
    if (uartGnt) uartGntCount++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic nextCycle;
    @(negedge clk);
  endtask

  function automatic int gntCode();
    return (cpuGnt ? 1 : 0) + (uartGnt ? 2 : 0);
  endfunction

  task automatic applyStimulus(input logic isUart, input logic req, input logic we,
                               input logic [4:0] adr, input logic [7:0] wdata);
    if (isUart) begin
      uartReq = req; uartWe = we; uartAdr = adr; uartWdata = wdata;
    end else begin
      cpuReq = req; cpuWe = we; cpuAdr = adr; cpuWdata = wdata;
    end
  endtask

  initial begin
    int grants [$];
    int code;
    int startUart;
    int expSeq [10];
    int lockSeq [7];
    int oddHits, evenHits;

    for (int i = 0; i < 32; i++) mem[i] = 8'h40 + 8'(i);
    ramRdata = 8'h00;
    rst = 1'b1;
    uartLock = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 8'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 8'd0);

    // Reset state
    nextCycle; nextCycle;
    checkOutput("rst_strobes", {cpuGnt, uartGnt, cpuRvalid, uartRvalid, ramWen}, 0);
    checkOutput("rst_ram_adr", ramAdr, 0);
    checkOutput("rst_ram_wdata", ramWdata, 0);
    checkOutput("rst_rdata", {cpuRdata, uartRdata}, 0);
    rst = 1'b0;
    nextCycle;

    // Test 1: CPU write then read of the same address
    startUart = uartGntCount;
    applyStimulus(1'b0, 1'b1, 1'b1, 5'd5, 8'hA3);
    nextCycle;
    checkOutput("t1_wr_gnt", {cpuGnt, uartGnt}, 2'b10);
    checkOutput("t1_wr_wen", ramWen, 1);
    checkOutput("t1_wr_adr", ramAdr, 5);
    checkOutput("t1_wr_data", ramWdata, 8'hA3);
    applyStimulus(1'b0, 1'b1, 1'b0, 5'd5, 8'h00);
    nextCycle;
    checkOutput("t1_arb_idle", {cpuGnt, cpuRvalid, ramWen}, 0);
    nextCycle;
    checkOutput("t1_rd_gnt", {cpuGnt, ramWen}, 2'b10);
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 8'h00);
    nextCycle;
    checkOutput("t1_rvalid", cpuRvalid, 1);
    checkOutput("t1_rdata", cpuRdata, 8'hA3);
    nextCycle;
    checkOutput("t1_rvalid_pulse", cpuRvalid, 0);
    checkOutput("t1_rdata_hold", cpuRdata, 8'hA3);
    checkOutput("t1_no_uart_gnt", uartGntCount - startUart, 0);

    // Test 2: both requesters held, starvation guard yields C,C,C,C,U
    expSeq = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2};
    applyStimulus(1'b0, 1'b1, 1'b0, 5'd1, 8'h00);
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd2, 8'h00);
    for (int c = 0; c < 20; c++) begin
      nextCycle;
      code = gntCode();
      if (code != 0) grants.push_back(code);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 8'h00);
    checkOutput("t2_grant_count", grants.size(), 10);
    for (int g = 0; g < 10; g++) begin
      checkOutput($sformatf("t2_grant%0d", g), (g < grants.size()) ? grants[g] : -1, expSeq[g]);
    end
    nextCycle; nextCycle;

    // Test 3: lock gives the UART exclusive grants, CPU wins right after
    lockSeq = '{2, 0, 2, 0, 2, 0, 1};
    uartLock = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0, 5'd3, 8'h00);
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd4, 8'h00);
    for (int c = 0; c < 7; c++) begin
      nextCycle;
      checkOutput($sformatf("t3_cycle%0d", c), gntCode(), lockSeq[c]);
      if (c == 4) uartLock = 1'b0;
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 8'h00);
    nextCycle; nextCycle;

    // Test 4: UART read of 31, then CPU read of 0 back to back
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd31, 8'h00);
    nextCycle;
    checkOutput("t4_uart_gnt", gntCode(), 2);
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 8'h00);
    applyStimulus(1'b0, 1'b1, 1'b0, 5'd0, 8'h00);
    nextCycle;
    checkOutput("t4_uart_rvalid", {uartRvalid, cpuRvalid}, 2'b10);
    checkOutput("t4_uart_rdata", uartRdata, 8'h5F);
    nextCycle;
    checkOutput("t4_cpu_gnt", {gntCode(), uartRvalid}, {32'd1, 1'b0});
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 8'h00);
    nextCycle;
    checkOutput("t4_cpu_rvalid", {uartRvalid, cpuRvalid}, 2'b01);
    checkOutput("t4_cpu_rdata", cpuRdata, 8'h40);
    checkOutput("t4_uart_rdata_hold", uartRdata, 8'h5F);
    nextCycle;

    // Test 5: reset during the ISSUE cycle of a read
    applyStimulus(1'b0, 1'b1, 1'b0, 5'd3, 8'h00);
    nextCycle;
    checkOutput("t5_gnt", gntCode(), 1);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 8'h00);
    nextCycle;
    checkOutput("t5_strobes", {cpuGnt, uartGnt, cpuRvalid, uartRvalid, ramWen}, 0);
    checkOutput("t5_ram_adr", ramAdr, 0);
    checkOutput("t5_rdata", {cpuRdata, uartRdata}, 0);
    rst = 1'b0;
    nextCycle;
    checkOutput("t5_no_late_rvalid", {cpuRvalid, uartRvalid}, 0);

    // Test 6: single UART writer holds req for 10 cycles
    oddHits = 0;
    evenHits = 0;
    applyStimulus(1'b1, 1'b1, 1'b1, 5'd9, 8'h77);
    for (int c = 1; c <= 10; c++) begin
      nextCycle;
      code = gntCode();
      if (code != 0) begin
        if (c % 2 == 1) oddHits++;
        else evenHits++;
      end
      if (c == 10) applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 8'h00);
    end
    checkOutput("t6_gnt_pulses", oddHits, 5);
    checkOutput("t6_gnt_spacing", evenHits, 0);
    nextCycle;
    checkOutput("t6_mem_written", mem[9], 8'h77);

    checkOutput("never_overlap", overlapCount, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
